// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB4 initiator.
// Takes commands on a valid/ready stream and runs one SETUP/ACCESS transfer per
// command, then returns one response on a valid/ready stream. A bounded
// wait-state timeout aborts transfers to a slave that never raises pready.
module apb_requester #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    // command stream
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic                      cmd_write,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    // response stream
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    // APB4 initiator side
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    // Counter only needs to hold values up to TIMEOUT_CYCLES-1: the abort
    // fires on the wait cycle that would bring it to TIMEOUT_CYCLES.
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
    localparam bit   TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // registered state and outputs
    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [2:0]             r_pprot;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [STRB_W-1:0]      r_pstrb;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_err;
    logic [CNT_W-1:0]       r_cnt;

    // next-state values
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  w_paddr_nxt;
    logic [2:0]             w_pprot_nxt;
    logic                   w_psel_nxt;
    logic                   w_penable_nxt;
    logic                   w_pwrite_nxt;
    logic [DATA_WIDTH-1:0]  w_pwdata_nxt;
    logic [STRB_W-1:0]      w_pstrb_nxt;
    logic                   w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]  w_rsp_rdata_nxt;
    logic                   w_rsp_err_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        w_state_nxt     = r_state;
        w_paddr_nxt     = r_paddr;
        w_pprot_nxt     = r_pprot;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Latch the command; psel rises with the move into SETUP.
                    w_paddr_nxt   = cmd_addr;
                    w_pprot_nxt   = cmd_prot;
                    w_pwrite_nxt  = cmd_write;
                    if (cmd_write) begin
                        w_pwdata_nxt = cmd_wdata;
                        w_pstrb_nxt  = cmd_strb;
                    end else begin
                        // Reads never expose stale write data on the bus.
                        w_pwdata_nxt = {DATA_WIDTH{1'b0}};
                        w_pstrb_nxt  = {STRB_W{1'b0}};
                    end
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_SETUP;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end

            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready) begin
                    // Completion wins over a timeout firing in the same cycle.
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    if (r_pwrite) begin
                        w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
                    end else begin
                        w_rsp_rdata_nxt = prdata;
                    end
                    w_rsp_err_nxt   = pslverr;
                    w_cnt_nxt       = {CNT_W{1'b0}};
                    w_state_nxt     = ST_RESP;
                end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
                    // Dead slave: abandon the transfer and report an error.
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
                    w_rsp_err_nxt   = 1'b1;
                    w_cnt_nxt       = {CNT_W{1'b0}};
                    w_state_nxt     = ST_RESP;
                end else if (TIMEOUT_EN) begin
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_state_nxt     = ST_ACCESS;
                end else begin
                    w_state_nxt     = ST_ACCESS;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt     = ST_RESP;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a quiet bus in IDLE.
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_cnt_nxt       = {CNT_W{1'b0}};
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops psel/penable immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            r_paddr     <= {ADDR_WIDTH{1'b0}};
            r_pprot     <= 3'b000;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= {DATA_WIDTH{1'b0}};
            r_pstrb     <= {STRB_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_err   <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pprot     <= w_pprot_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign paddr     = r_paddr;
    assign pprot     = r_pprot;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Single-outstanding APB4 initiator that turns a valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns one response per command on a valid/ready response stream.
- Sits between an internal controller and the APB register peripherals on the same bus.
- Includes a bounded wait-state timeout, so a dead slave cannot hang the requester.

Parameters:
- ADDR_WIDTH, 3, width of cmd_addr and paddr.
- DATA_WIDTH, 8, data width; multiple of 8.
- TIMEOUT_CYCLES, 16, ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  input  1  clock; all logic rising-edge.
- presetn  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a pclk edge.
- cmd_addr  input  ADDR_WIDTH  target address.
- cmd_write  input  1  1=write, 0=read.
- cmd_wdata  input  DATA_WIDTH  write data.
- cmd_strb  input  DATA_WIDTH/8  write byte strobes.
- cmd_prot  input  3  protection attributes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a pclk edge.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and aborted transfers.
- rsp_err  output  1  1 = pslverr returned or timeout abort.
- paddr  output  ADDR_WIDTH  APB address.
- pprot  output  3  APB protection.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_WIDTH  APB write data.
- pstrb  output  DATA_WIDTH/8  APB strobes.
- pready  input  1  slave ready.
- prdata  input  DATA_WIDTH  slave read data.
- pslverr  input  1  slave error.

Behaviour:
- Reset (async, presetn low):
  - State IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot = 0.
  - rsp_valid, rsp_rdata, rsp_err = 0.
  - Timeout counter = 0.
  - cmd_ready = 1, since it is decoded from state == IDLE.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On a command handshake, latch addr, write, prot; next state SETUP.
  - For writes, latch wdata and strb. For reads, drive pwdata = 0 and pstrb = 0.
- SETUP: psel = 1, penable = 0; next state ACCESS unconditionally.
- ACCESS:
  - psel = 1, penable = 1. Sample pready every cycle.
  - pready = 1: capture rsp_rdata = prdata for reads (0 for writes) and rsp_err = pslverr. Drop psel and penable, assert rsp_valid; next state RESP.
  - pready = 0: increment the timeout counter.
  - Timeout: when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, abort. Drop psel and penable, rsp_err = 1, rsp_rdata = 0; next state RESP.
  - pready = 1 in the cycle the timeout would fire: normal completion wins.
  - The counter clears on leaving ACCESS.
- RESP:
  - rsp_valid, rsp_rdata, rsp_err held stable until the response handshake.
  - Then rsp_valid = 0; next state IDLE.
- Latency:
  - Command accepted at edge N.
  - SETUP during N..N+1, ACCESS from N+1.
  - With zero wait states, rsp_valid = 1 after edge N+2.
  - Each wait state adds one cycle.
  - Back-to-back throughput with rsp_ready held high: one transfer per 4 cycles.
- Bus stability:
  - paddr, pwrite, pwdata, pstrb, pprot are stable from SETUP until ACCESS completes.
  - paddr, pwrite, pprot hold their last values in IDLE.
  - psel is never high in IDLE or RESP; penable is only high in ACCESS.
- cmd_ready is 0 in SETUP, ACCESS and RESP; only one transfer is ever outstanding.
- Reset mid-transfer:
  - psel and penable drop immediately (asynchronously).
  - No response is generated for the interrupted command.

Test Plan:
- Write, zero-wait slave: addr=5, wdata=0xA5, strb=1.
  - APB: psel 1 cycle with penable=0, then 1 cycle with penable=1, paddr=5, pwrite=1, pwdata=0xA5.
  - rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Slave holds pready low for 3 ACCESS cycles, then returns prdata=0x3C.
  - paddr stable throughout; rsp_rdata=0x3C, rsp_err=0; rsp_valid 6 cycles after acceptance.
- Slave error: pready=1 and pslverr=1 on the first ACCESS cycle -> rsp_err=1.
- Timeout, TIMEOUT_CYCLES=4, pready stuck low:
  - Exactly 4 ACCESS cycles, then psel drops.
  - rsp_err=1, rsp_rdata=0; next command accepted normally.
- Response backpressure:
  - rsp_ready low for 5 cycles: rsp_valid and data held, cmd_ready=0 throughout.
  - Raise rsp_ready: IDLE next cycle; a second queued command starts SETUP one cycle later.
- Reset mid-ACCESS:
  - Drop presetn: psel, penable, rsp_valid go 0 without a clock edge.
  - After release, cmd_ready=1 and no stale response appears.
